vr_mem_arbiter: RTL

- Shares one single-port synchronous BRAM and the memory-mapped IO bus between two masters.
- M0 is the RV32I core data/instruction port; M1 is the program loader / DMA port.
- Each access is decoded to RAM or IO by one address bit.
- Masters use a hold-until-ready request handshake. Round-robin arbitration gives a bounded, one-access worst-case wait.

---
 rtl/vr_mem_pkg.sv | 11 +
 rtl/vr_mem_arbiter_if.sv | 39 +++
 rtl/vr_rr_arb2.sv | 18 +
 rtl/vr_mem_arbiter.sv | 90 +++++++++
 4 files changed

// File: rtl/vr_mem_pkg.sv
// vr_mem_pkg: memory-map constants and arbiter state encoding shared by CPU, IO and arbiter
package vr_mem_pkg;
    localparam int DEF_RAM_AW = 11;
    localparam int DEF_IO_BIT = 22;
    localparam int DEF_IO_AW  = 6;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;
endpackage

// File: rtl/vr_mem_arbiter_if.sv
// vr_mem_arbiter_if: two request ports plus the shared RAM and IO bus
interface vr_mem_arbiter_if
    import vr_mem_pkg::*;
#(
    parameter int RAM_AW = DEF_RAM_AW,
    parameter int IO_AW  = DEF_IO_AW
);
    logic [31:0]       m0_addr, m0_wdata, m0_rdata;
    logic              m0_ren, m0_ready;
    logic [3:0]        m0_wmask;
    logic [31:0]       m1_addr, m1_wdata, m1_rdata;
    logic              m1_ren, m1_ready;
    logic [3:0]        m1_wmask;
    logic [RAM_AW-1:0] ram_addr;
    logic              ram_ren;
    logic [3:0]        ram_wmask;
    logic [31:0]       ram_wdata, ram_rdata;
    logic [IO_AW-1:0]  io_addr;
    logic              io_ren, io_wen;
    logic [31:0]       io_wdata, io_rdata;

    modport slave (
        input  m0_addr, m0_ren, m0_wmask, m0_wdata,
        input  m1_addr, m1_ren, m1_wmask, m1_wdata,
        input  ram_rdata, io_rdata,
        output m0_rdata, m0_ready, m1_rdata, m1_ready,
        output ram_addr, ram_ren, ram_wmask, ram_wdata,
        output io_addr, io_ren, io_wen, io_wdata
    );

    modport master (
        output m0_addr, m0_ren, m0_wmask, m0_wdata,
        output m1_addr, m1_ren, m1_wmask, m1_wdata,
        output ram_rdata, io_rdata,
        input  m0_rdata, m0_ready, m1_rdata, m1_ready,
        input  ram_addr, ram_ren, ram_wmask, ram_wdata,
        input  io_addr, io_ren, io_wen, io_wdata
    );
endinterface

// File: rtl/vr_rr_arb2.sv
// vr_rr_arb2: two-way round-robin arbiter, combinational grant, registered last-winner pointer
module vr_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic last;

    assign gnt = !en ? 2'b00 : &req ? (last ? 2'b01 : 2'b10) : req;

    // remember who won; reset favours M0 on the first tie
    always_ff @(posedge clk) begin
        if (rst) last <= 1'b1;
        else if (|gnt) last <= gnt[1];
    end
endmodule

// File: rtl/vr_mem_arbiter.sv
// vr_mem_arbiter: shares one BRAM and the IO bus between two masters, IDLE/ACCESS/RESP per access
module vr_mem_arbiter
    import vr_mem_pkg::*;
#(
    parameter int RAM_AW = DEF_RAM_AW,
    parameter int IO_BIT = DEF_IO_BIT,
    parameter int IO_AW  = DEF_IO_AW
) (
    input logic             i_clk,
    input logic             i_rst,
    vr_mem_arbiter_if.slave bus
);
    state_t            state, state_nx;
    logic [1:0]        req, gnt;
    logic              idle, acc, resp;
    logic [31:0]       win_addr, win_wdata;
    logic [3:0]        win_wmask;
    logic              win_ren;
    logic              sel_q, rd_q, io_q;
    logic [RAM_AW-1:0] ram_a_q;
    logic [IO_AW-1:0]  io_a_q;
    logic [3:0]        wmask_q;
    logic [31:0]       wdata_q, io_rdata_q, rdata;

    assign req       = {bus.m1_ren | (|bus.m1_wmask), bus.m0_ren | (|bus.m0_wmask)};
    assign idle      = state == ST_IDLE;
    assign acc       = state == ST_ACCESS;
    assign resp      = state == ST_RESP;
    assign win_addr  = gnt[1] ? bus.m1_addr  : bus.m0_addr;
    assign win_ren   = gnt[1] ? bus.m1_ren   : bus.m0_ren;
    assign win_wmask = gnt[1] ? bus.m1_wmask : bus.m0_wmask;
    assign win_wdata = gnt[1] ? bus.m1_wdata : bus.m0_wdata;

    vr_rr_arb2 u_arb (
        .clk (i_clk),
        .rst (i_rst),
        .en  (idle),
        .req (req),
        .gnt (gnt)
    );

    // state register
    always_ff @(posedge i_clk) begin
        state <= i_rst ? ST_IDLE : state_nx;
    end

    // latch the winner's request in IDLE; capture IO read data during ACCESS
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sel_q      <= 1'b0;
            rd_q       <= 1'b0;
            io_q       <= 1'b0;
            ram_a_q    <= '0;
            io_a_q     <= '0;
            wmask_q    <= '0;
            wdata_q    <= '0;
            io_rdata_q <= '0;
        end else begin
            if (idle && |req) begin
                sel_q   <= gnt[1];
                rd_q    <= win_ren & ~|win_wmask;
                io_q    <= win_addr[IO_BIT];
                ram_a_q <= win_addr[RAM_AW+1:2];
                io_a_q  <= win_addr[IO_AW+1:2];
                wmask_q <= win_wmask;
                wdata_q <= win_wdata;
            end
            if (acc && io_q && rd_q) io_rdata_q <= bus.io_rdata;
        end
    end

    // next state and bus outputs, all driven from latched copies only
    always_comb begin
        state_nx      = ST_IDLE;
        state_nx      = idle ? (|req ? ST_ACCESS : ST_IDLE) : acc ? ST_RESP : ST_IDLE;
        rdata         = rd_q ? (io_q ? io_rdata_q : bus.ram_rdata) : '0;
        bus.ram_addr  = (acc && !io_q) ? ram_a_q : '0;
        bus.ram_ren   = acc && !io_q && rd_q;
        bus.ram_wmask = (acc && !io_q) ? wmask_q : '0;
        bus.ram_wdata = (acc && !io_q) ? wdata_q : '0;
        bus.io_addr   = (acc && io_q) ? io_a_q : '0;
        bus.io_ren    = acc && io_q && rd_q;
        bus.io_wen    = acc && io_q && |wmask_q;
        bus.io_wdata  = (acc && io_q) ? wdata_q : '0;
        bus.m0_ready  = resp && !sel_q;
        bus.m1_ready  = resp && sel_q;
        bus.m0_rdata  = (resp && !sel_q) ? rdata : '0;
        bus.m1_rdata  = (resp && sel_q) ? rdata : '0;
    end
endmodule
